alu_issue_stage: RTL and testbench

Issue stage on the producer side of the ALU's `Ctl`/`Shamt`/`DataA`/`DataB` interface, sitting in EX between the ID/EX boundary and the ALU. It decodes main-control `ALUOp` plus R-type `Funct` into the 3-bit ALU operation code and gates `Shamt`. It registers the decoded operation with its operands in a two-entry skid buffer, giving full-throughput valid/ready handshaking with stall and flush support.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_ctl_decode.sv | 41 ++++
 rtl/alu_issue_stage.sv | 108 ++++++++++
 tb/tb_alu_issue_stage.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: ALU control codes, main-control
// ALUOp encodings, R-type function codes and the skid-buffer state type.
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [2:0] ALU_SRL = 3'b011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_SRL = 6'b000010;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

endpackage

// File: rtl/alu_ctl_decode.sv
// Combinational ALU control decode: main-control ALUOp plus R-type Funct into
// the 3-bit ALU operation, with the shift amount passed only for srl.
module alu_ctl_decode
  import alu_pkg::*;
(
  input  logic [1:0] aluOp_i,
  input  logic [5:0] funct_i,
  input  logic [4:0] shamt_i,
  output logic [2:0] ctl_o,
  output logic [4:0] shamt_o,
  output logic       illegal_o
);

  // Unsupported R-type functions (including the all-zero nop) fall back to add
  always_comb begin
    ctl_o     = ALU_ADD;
    illegal_o = 1'b0;
    case (aluOp_i)
      ALUOP_ADD: ctl_o = ALU_ADD;
      ALUOP_SUB: ctl_o = ALU_SUB;
      ALUOP_OR:  ctl_o = ALU_OR;
      default: begin
        case (funct_i)
          FUNCT_ADD: ctl_o = ALU_ADD;
          FUNCT_SUB: ctl_o = ALU_SUB;
          FUNCT_AND: ctl_o = ALU_AND;
          FUNCT_OR:  ctl_o = ALU_OR;
          FUNCT_SLT: ctl_o = ALU_SLT;
          FUNCT_SRL: ctl_o = ALU_SRL;
          default: begin
            ctl_o     = ALU_ADD;
            illegal_o = 1'b1;
          end
        endcase
      end
    endcase
  end

  assign shamt_o = (ctl_o == ALU_SRL) ? shamt_i : 5'd0;

endmodule

// File: rtl/alu_issue_stage.sv
// EX issue stage: decodes the ALU operation and holds it with its operands in a
// two-entry skid buffer so the valid/ready handshake runs at full throughput.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAGW  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             InValid,
  output logic             InReady,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       Funct,
  input  logic [4:0]       ShamtIn,
  input  logic [WIDTH-1:0] DataAIn,
  input  logic [WIDTH-1:0] DataBIn,
  input  logic [TAGW-1:0]  TagIn,
  input  logic             Flush,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [2:0]       Ctl,
  output logic [4:0]       Shamt,
  output logic [WIDTH-1:0] DataA,
  output logic [WIDTH-1:0] DataB,
  output logic [TAGW-1:0]  Tag,
  output logic             Illegal
);

  localparam int EntryW = 3 + 5 + 2 * WIDTH + TAGW + 1;

  logic [2:0]        decCtl;
  logic [4:0]        decShamt;
  logic              decIllegal;
  logic [EntryW-1:0] inEntry;
  logic [EntryW-1:0] main_q, main_d;
  logic [EntryW-1:0] skid_q, skid_d;
  stage_state_e      state_q, state_d;
  logic              inFire, outFire;

  alu_ctl_decode uDecode (
    .aluOp_i   (ALUOp),
    .funct_i   (Funct),
    .shamt_i   (ShamtIn),
    .ctl_o     (decCtl),
    .shamt_o   (decShamt),
    .illegal_o (decIllegal)
  );

  assign inEntry  = {decCtl, decShamt, DataAIn, DataBIn, TagIn, decIllegal};
  assign InReady  = (state_q != FULL);
  assign OutValid = (state_q != EMPTY);
  assign inFire   = InValid & InReady;
  assign outFire  = OutValid & OutReady;

  // Main register always holds the oldest entry; skid only fills when stalled
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (Flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (inFire) begin
            state_d = ONE;
            main_d  = inEntry;
          end
        end
        ONE: begin
          if (inFire && !outFire) begin
            state_d = FULL;
            skid_d  = inEntry;
          end else if (inFire && outFire) begin
            main_d = inEntry;
          end else if (outFire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (outFire) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign {Ctl, Shamt, DataA, DataB, Tag, Illegal} = main_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed phases plus a random run,
// all compared against a queue-based model of the two-entry buffer.
module tb_alu_issue_stage;

  localparam int WIDTH = 32;
  localparam int TAGW  = 5;

  typedef struct packed {
    logic [2:0]       ctl;
    logic [4:0]       shamt;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [TAGW-1:0]  tag;
    logic             ill;
  } entry_t;

  typedef struct packed {
    logic [1:0]       op;
    logic [5:0]       f;
    logic [4:0]       sh;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [TAGW-1:0]  tag;
  } raw_t;

  logic             clk;
  logic             rst_n;
  logic             InValid;
  logic             InReady;
  logic [1:0]       ALUOp;
  logic [5:0]       Funct;
  logic [4:0]       ShamtIn;
  logic [WIDTH-1:0] DataAIn;
  logic [WIDTH-1:0] DataBIn;
  logic [TAGW-1:0]  TagIn;
  logic             Flush;
  logic             OutValid;
  logic             OutReady;
  logic [2:0]       Ctl;
  logic [4:0]       Shamt;
  logic [WIDTH-1:0] DataA;
  logic [WIDTH-1:0] DataB;
  logic [TAGW-1:0]  Tag;
  logic             Illegal;

  alu_issue_stage #(.WIDTH(WIDTH), .TAGW(TAGW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .InValid  (InValid),
    .InReady  (InReady),
    .ALUOp    (ALUOp),
    .Funct    (Funct),
    .ShamtIn  (ShamtIn),
    .DataAIn  (DataAIn),
    .DataBIn  (DataBIn),
    .TagIn    (TagIn),
    .Flush    (Flush),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .Ctl      (Ctl),
    .Shamt    (Shamt),
    .DataA    (DataA),
    .DataB    (DataB),
    .Tag      (Tag),
    .Illegal  (Illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  entry_t           model[$];
  raw_t             pending[$];
  logic [WIDTH-1:0] delivered[$];
  bit               cleared;
  bit               lastAccepted;
  int               checks;
  int               errors;
  int               cycle;
  int               outFireCount;
  int               firstFire;
  int               lastFire;

  logic [5:0] legalF [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000010};
  logic [1:0] swOp   [10] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b11, 2'b10};
  logic [5:0] swF    [10] = '{6'b100100, 6'b100101, 6'b100000, 6'b100010, 6'b101010, 6'b000010,
                              6'b000000, 6'b000000, 6'b000000, 6'b011000};
  logic [2:0] swCtl  [10] = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b011, 3'b010, 3'b110, 3'b001, 3'b010};
  logic [4:0] swSh   [10] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 5'd0, 5'd0};
  logic       swIll  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  // Reference decode written straight from the ALU control table
  function automatic entry_t refEntry(input raw_t r);
    entry_t e;
    e.ill = 1'b0;
    e.ctl = 3'b010;
    case (r.op)
      2'b00: e.ctl = 3'b010;
      2'b01: e.ctl = 3'b110;
      2'b11: e.ctl = 3'b001;
      default: begin
        case (r.f)
          6'b100000: e.ctl = 3'b010;
          6'b100010: e.ctl = 3'b110;
          6'b100100: e.ctl = 3'b000;
          6'b100101: e.ctl = 3'b001;
          6'b101010: e.ctl = 3'b111;
          6'b000010: e.ctl = 3'b011;
          default: begin
            e.ctl = 3'b010;
            e.ill = 1'b1;
          end
        endcase
      end
    endcase
    e.shamt = (e.ctl == 3'b011) ? r.sh : 5'd0;
    e.a     = r.a;
    e.b     = r.b;
    e.tag   = r.tag;
    return e;
  endfunction

  function automatic raw_t randRaw();
    raw_t r;
    r.op  = 2'($urandom_range(0, 3));
    r.f   = ($urandom_range(0, 1) == 1) ? legalF[$urandom_range(0, 5)] : 6'($urandom);
    r.sh  = 5'($urandom);
    r.a   = $urandom;
    r.b   = $urandom;
    r.tag = TAGW'($urandom);
    if (r.op == 2'b00 && r.f == 6'd0 && r.sh == 5'd0) r.sh = 5'd1;
    return r;
  endfunction

  task automatic checkVal(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  task automatic applyStimulus(input bit valid, input raw_t r);
    InValid = valid;
    ALUOp   = r.op;
    Funct   = r.f;
    ShamtIn = r.sh;
    DataAIn = r.a;
    DataBIn = r.b;
    TagIn   = r.tag;
  endtask

  task automatic checkOutput();
    entry_t obs;
    obs = {Ctl, Shamt, DataA, DataB, Tag, Illegal};
    checkVal("InReady", 128'(InReady), 128'(model.size() < 2));
    checkVal("OutValid", 128'(OutValid), 128'(model.size() > 0));
    if (model.size() > 0) checkVal("head", 128'(obs), 128'(model[0]));
    else if (cleared) checkVal("clearedPayload", 128'(obs), 128'(0));
  endtask

  // One clock: check at negedge, then advance the model across the posedge
  task automatic stepCycle();
    bit inFire, outFire;
    raw_t r;
    @(negedge clk);
    checkOutput();
    if (OutValid === 1'b1 && OutReady) begin
      delivered.push_back(DataA);
      if (outFireCount == 0) firstFire = cycle;
      lastFire = cycle;
      outFireCount++;
    end
    inFire  = InValid && (model.size() < 2);
    outFire = OutReady && (model.size() > 0);
    r = '{op: ALUOp, f: Funct, sh: ShamtIn, a: DataAIn, b: DataBIn, tag: TagIn};
    lastAccepted = 1'b0;
    @(posedge clk);
    if (!rst_n || Flush) begin
      model.delete();
      cleared = 1'b1;
    end else begin
      if (outFire) void'(model.pop_front());
      if (inFire) begin
        model.push_back(refEntry(r));
        cleared      = 1'b0;
        lastAccepted = 1'b1;
      end
    end
    cycle++;
    #1;
  endtask

  task automatic runStream(input int n);
    repeat (n) begin
      if (pending.size() > 0) applyStimulus(1'b1, pending[0]);
      else InValid = 1'b0;
      stepCycle();
      if (lastAccepted) void'(pending.pop_front());
    end
  endtask

  task automatic drain();
    InValid  = 1'b0;
    Flush    = 1'b0;
    OutReady = 1'b1;
    repeat (3) stepCycle();
  endtask

  initial begin
    raw_t r;
    checks = 0; errors = 0; cycle = 0; outFireCount = 0; firstFire = 0; lastFire = 0;
    cleared = 1'b1; lastAccepted = 1'b0;

    // Reset held two cycles with InValid high
    rst_n = 1'b0; Flush = 1'b0; OutReady = 1'b0;
    applyStimulus(1'b1, randRaw());
    @(posedge clk);
    #1;
    stepCycle();
    rst_n = 1'b1;
    InValid = 1'b0;
    checkVal("resetInReady", 128'(InReady), 128'(1));
    checkVal("resetOutValid", 128'(OutValid), 128'(0));
    checkVal("resetCtl", 128'(Ctl), 128'(0));
    checkVal("resetIllegal", 128'(Illegal), 128'(0));
    stepCycle();

    // Decode sweep with the consumer always ready
    $display("[TB] decode sweep");
    OutReady = 1'b1;
    for (int i = 0; i < 10; i++) begin
      r = randRaw();
      r.op = swOp[i]; r.f = swF[i]; r.sh = 5'd7;
      applyStimulus(1'b1, r);
      stepCycle();
      checkVal("sweepOutValid", 128'(OutValid), 128'(1));
      checkVal("sweepCtl", 128'(Ctl), 128'(swCtl[i]));
      checkVal("sweepShamt", 128'(Shamt), 128'(swSh[i]));
      checkVal("sweepIllegal", 128'(Illegal), 128'(swIll[i]));
    end
    drain();

    // Back-pressure: four entries against a stalled consumer
    $display("[TB] back-pressure");
    OutReady = 1'b0;
    delivered.delete();
    for (int i = 1; i <= 4; i++) begin
      r = randRaw();
      r.a = WIDTH'(i);
      pending.push_back(r);
    end
    runStream(4);
    checkVal("bpInReady", 128'(InReady), 128'(0));
    checkVal("bpDataA", 128'(DataA), 128'(1));
    runStream(2);
    checkVal("bpDataAStable", 128'(DataA), 128'(1));
    OutReady = 1'b1;
    runStream(8);
    checkVal("bpCount", 128'(delivered.size()), 128'(4));
    for (int i = 0; i < delivered.size(); i++)
      checkVal("bpOrder", 128'(delivered[i]), 128'(i + 1));
    drain();

    // Streaming 100 back-to-back entries
    $display("[TB] streaming");
    outFireCount = 0;
    for (int i = 0; i < 100; i++) pending.push_back(randRaw());
    OutReady = 1'b1;
    runStream(103);
    checkVal("streamFires", 128'(outFireCount), 128'(100));
    checkVal("streamSpan", 128'(lastFire - firstFire), 128'(99));
    drain();

    // Flush while FULL with a new input presented
    $display("[TB] flush");
    OutReady = 1'b0;
    pending.push_back(randRaw());
    pending.push_back(randRaw());
    runStream(2);
    checkVal("flushPreInReady", 128'(InReady), 128'(0));
    applyStimulus(1'b1, randRaw());
    Flush = 1'b1;
    stepCycle();
    Flush = 1'b0;
    InValid = 1'b0;
    checkVal("flushOutValid", 128'(OutValid), 128'(0));
    checkVal("flushInReady", 128'(InReady), 128'(1));
    OutReady = 1'b1;
    outFireCount = 0;
    repeat (3) stepCycle();
    checkVal("flushNoOut", 128'(outFireCount), 128'(0));

    // Random traffic against the model
    $display("[TB] random traffic");
    repeat (10000) begin
      applyStimulus(1'($urandom_range(0, 1)), randRaw());
      OutReady = ($urandom_range(0, 3) != 0);
      Flush    = ($urandom_range(0, 499) == 0);
      stepCycle();
    end
    drain();
    checkVal("finalEmpty", 128'(model.size()), 128'(0));
    checkVal("finalOutValid", 128'(OutValid), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
